// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Writer side of the instruction memory. Bytes from the host link are packed
//   big-endian into 32-bit words: a header word carrying the word count N,
//   then N instruction words. Each word is written to the instruction RAM at
//   BASE_ADDR + 4*index. The CPU is held in stall while a load is in progress
//   and released when the load completes.
//
//   Optional feature (macro IMEM_LOADER_CHECKSUM_EN): after the data words, one
//   more word is received and compared against the mod-2^32 sum of the data
//   words. A match ends in DONE and a mismatch ends in ERR.
//
// Handshake: a byte transfers on a rising clock edge where i_in_valid and
//   o_in_ready are both 1. o_in_ready is high only while a load is collecting
//   bytes. i_in_valid may drop at any time, and gaps between bytes are allowed.
//
// Ports:
//   i_clk, i_rst_n    clock (rising edge) and asynchronous active-low reset
//   i_start           one-cycle load request, honoured in IDLE, DONE and ERR
//   i_in_valid/_data  byte stream input
//   o_in_ready        loader accepts a byte this cycle
//   o_wr_en           one-cycle RAM write strobe
//   o_wr_addr/_data   RAM write byte address and word; both hold when idle
//   o_cpu_hold        stall request to the CPU
//   o_done, o_error   load completed or aborted (levels)
//   o_words_loaded    number of words written in the current load
//   o_state           FSM state, for debug visibility
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int          DEPTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_in_valid,
  input  logic [7:0]       i_in_data,
  output logic             o_in_ready,
  output logic             o_wr_en,
  output logic [31:0]      o_wr_addr,
  output logic [31:0]      o_wr_data,
  output logic             o_cpu_hold,
  output logic             o_done,
  output logic             o_error,
  output logic [CNT_W-1:0] o_words_loaded,
  output logic [2:0]       o_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_DATA = 3'd2,
    S_DONE = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_ERR  = 3'd4,
    S_CHK  = 3'd5
`else
    S_ERR  = 3'd4
`endif
  } state_t;

  state_t           r_state;
  logic [1:0]       r_byte_cnt;
  logic [23:0]      r_shift;     // earlier bytes of the word being assembled
  logic [CNT_W-1:0] r_n;         // word count taken from the header
  logic [CNT_W-1:0] r_words;
  logic             r_in_ready;
  logic             r_wr_en;
  logic [31:0]      r_wr_addr;
  logic [31:0]      r_wr_data;
  logic             r_cpu_hold;
  logic             r_done;
  logic             r_error;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]      r_sum;
`endif

  logic             w_fire;
  logic             w_last;
  logic [31:0]      w_word;

  assign w_fire = i_in_valid && r_in_ready;
  assign w_last = (r_byte_cnt == 2'd3);
  // The word is complete when its fourth byte is on the input bus.
  assign w_word = {r_shift, i_in_data};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_byte_cnt <= 2'd0;
      r_shift    <= 24'd0;
      r_n        <= '0;
      r_words    <= '0;
      r_in_ready <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= 32'd0;
      r_wr_data  <= 32'd0;
      r_cpu_hold <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_sum      <= 32'd0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (i_start) begin
            r_state    <= S_HDR;
            r_byte_cnt <= 2'd0;
            r_words    <= '0;
            r_in_ready <= 1'b1;
            r_cpu_hold <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum      <= 32'd0;
`endif
          end
        end

        S_HDR: begin
          if (w_fire) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_shift    <= {r_shift[15:0], i_in_data};
            if (w_last) begin
              if (w_word > 32'(DEPTH)) begin
                r_state    <= S_ERR;
                r_in_ready <= 1'b0;
                r_error    <= 1'b1;
              end else if (w_word == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_state    <= S_CHK;
`else
                r_state    <= S_DONE;
                r_in_ready <= 1'b0;
                r_cpu_hold <= 1'b0;
                r_done     <= 1'b1;
`endif
              end else begin
                r_n     <= w_word[CNT_W-1:0];
                r_state <= S_DATA;
              end
            end
          end
        end

        S_DATA: begin
          if (w_fire) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_shift    <= {r_shift[15:0], i_in_data};
            if (w_last) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= BASE_ADDR + (32'(r_words) << 2);
              r_wr_data <= w_word;
              r_words   <= r_words + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
              r_sum     <= r_sum + w_word;
`endif
              if ((r_words + 1'b1) == r_n) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_state    <= S_CHK;
`else
                r_state    <= S_DONE;
                r_in_ready <= 1'b0;
                r_cpu_hold <= 1'b0;
                r_done     <= 1'b1;
`endif
              end
            end
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (w_fire) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_shift    <= {r_shift[15:0], i_in_data};
            if (w_last) begin
              r_in_ready <= 1'b0;
              if (w_word == r_sum) begin
                r_state    <= S_DONE;
                r_cpu_hold <= 1'b0;
                r_done     <= 1'b1;
              end else begin
                // Writes already issued stay in the RAM; the CPU stays held.
                r_state    <= S_ERR;
                r_error    <= 1'b1;
              end
            end
          end
        end
`endif

        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready     = r_in_ready;
  assign o_wr_en        = r_wr_en;
  assign o_wr_addr      = r_wr_addr;
  assign o_wr_data      = r_wr_data;
  assign o_cpu_hold     = r_cpu_hold;
  assign o_done         = r_done;
  assign o_error        = r_error;
  assign o_words_loaded = r_words;
  assign o_state        = r_state;

endmodule
